ram_loader: RTL and testbench

Program loader sitting directly upstream of the 16x8 program/data RAM. Accepts a byte stream over a valid/ready handshake and drives the RAM write port (address, data, write enable) to fill words 0..NUM_WORDS-1 in order. Holds the CPU off the bus via cpu_hold while loading, so the run-time MAR/RAM path and the loader never drive the RAM simultaneously. Byte source is a UART receiver or a testbench.

---
 rtl/loader_pkg.sv | 15 +
 rtl/ram_loader.sv | 113 +++++++++++
 tb/tb_ram_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and default sizing for the RAM program loader.
package loader_pkg;

   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_NUM_WORDS  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ram_loader.sv
// Streams bytes into the program RAM words 0..NUM_WORDS-1 while holding the CPU off the bus.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start, bus released
// LOAD  | accepting data bytes, one RAM write per accepted byte
// CHECK | accepting the checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | session complete, waiting for a new start
module ram_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_WORDS  = DEF_NUM_WORDS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  busy,
   output logic                  done,
   output logic                  cpu_hold,
   output logic                  error
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

`ifdef LOADER_CHECKSUM_EN
   localparam state_t AFTER_LAST = CHECK;
`else
   localparam state_t AFTER_LAST = DONE;
`endif

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] count;
   logic                  hs;
   logic                  start_ok;
   logic                  last_hs;

   assign in_ready = (state == LOAD) || (state == CHECK);
   assign hs       = in_valid & in_ready;
   assign start_ok = start && ((state == IDLE) || (state == DONE));
   assign last_hs  = (state == LOAD) && hs && (count == LAST_ADDR);

   // The final write pulse lands in the first cycle after LOAD, so busy covers it.
   assign busy     = in_ready | ram_we;
   assign cpu_hold = busy;
   assign done     = (state == DONE) && !ram_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)   state_nxt = LOAD;
         LOAD:    if (last_hs) state_nxt = AFTER_LAST;
         CHECK:   if (hs)      state_nxt = DONE;
         DONE:    if (start)   state_nxt = LOAD;
         default:              state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= '0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
      end else begin
         ram_we <= 1'b0;
         if (start_ok) begin
            count <= '0;
         end else if ((state == LOAD) && hs) begin
            ram_we   <= 1'b1;
            ram_addr <= count;
            ram_data <= in_data;
            if (count != LAST_ADDR) count <= count + ADDR_WIDTH'(1);
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] sum;
   logic                  error_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum     <= '0;
         error_q <= 1'b0;
      end else if (start_ok) begin
         sum     <= '0;
         error_q <= 1'b0;
      end else if ((state == LOAD) && hs) begin
         sum <= sum + in_data;
      end else if ((state == CHECK) && hs) begin
         error_q <= (in_data != sum);
      end
   end

   assign error = error_q;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: random byte streams, expected writes queued at handshake.
module tb_ram_loader;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          reset, start, in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready, ram_we, busy, done, cpu_hold, error;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;

   ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
      .busy(busy), .done(done), .cpu_hold(cpu_hold), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            due;
   } wr_t;

   wr_t           exp_q[$];
   logic [DW-1:0] exp_mem[NW];
   logic [DW-1:0] got_mem[NW];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            sess_idx = 0;
   int            wr_count = 0;
   logic [DW-1:0] sess_sum = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every write pulse must match the oldest outstanding accepted byte.
   always @(negedge clk) begin
      wr_t e;
      if (!reset && ram_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_write: got addr %0h data %0h expected no write", ram_addr, ram_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", ram_addr, e.addr);
            check("wr_data", ram_data, e.data);
            check("wr_latency", cyc, e.due);
            check("busy_on_write", busy, 1);
         end
         got_mem[ram_addr] = ram_data;
         wr_count++;
      end
   end

   task automatic send_raw(input logic [DW-1:0] b, input int gap, output bit ok);
      bit acc;
      acc = 1'b0;
      repeat (gap) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      for (int t = 0; t < 8; t++) begin
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) break;
      end
      in_valid = 1'b0;
      ok = acc;
   endtask

   task automatic send_data(input logic [DW-1:0] b, input int gap);
      bit ok;
      wr_t e;
      send_raw(b, gap, ok);
      check("byte_accepted", ok, 1);
      if (ok) begin
         e.addr = AW'(sess_idx);
         e.data = b;
         e.due  = cyc;
         exp_q.push_back(e);
         exp_mem[sess_idx] = b;
         sess_sum = sess_sum + b;
         sess_idx++;
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      sess_idx = 0;
      sess_sum = '0;
      wr_count = 0;
      check("start_busy", busy, 1);
      check("start_hold", cpu_hold, 1);
      check("start_done_clr", done, 0);
      check("start_ready", in_ready, 1);
      check("start_err_clr", error, 0);
   endtask

   task automatic end_session(input bit bad);
      bit got_done;
`ifdef LOADER_CHECKSUM_EN
      bit ok;
      check("ready_in_check", in_ready, 1);
      send_raw(bad ? sess_sum + 8'd1 : sess_sum, $urandom_range(0, 1), ok);
      check("cksum_accepted", ok, 1);
`else
      check("ready_drop", in_ready, 0);
`endif
      got_done = 1'b0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk); #1;
         if (done) begin
            got_done = 1'b1;
            break;
         end
      end
      check("done_seen", got_done, 1);
      check("done_busy", busy, 0);
      check("done_hold", cpu_hold, 0);
      check("done_ready", in_ready, 0);
`ifdef LOADER_CHECKSUM_EN
      check("error_flag", error, bad);
`else
      check("error_flag", error, 0);
`endif
      check("write_count", wr_count, NW);
      check("queue_drained", exp_q.size(), 0);
      // Bytes offered in DONE must be ignored.
      in_valid = 1'b1;
      in_data  = 8'h5C;
      repeat (3) @(posedge clk);
      #1 in_valid = 1'b0;
      check("done_held", done, 1);
      check("done_no_write", wr_count, NW);
      for (int i = 0; i < NW; i++) check("mem_word", got_mem[i], exp_mem[i]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      bit bad;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      for (int i = 0; i < NW; i++) begin
         exp_mem[i] = '0;
         got_mem[i] = '0;
      end
      #3;
      check("rst_we", ram_we, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_data", ram_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hold", cpu_hold, 0);
      check("rst_err", error, 0);
      check("rst_ready", in_ready, 0);
      @(posedge clk); #2 reset = 1'b0;
      @(posedge clk); #1;

      // Bytes in IDLE are ignored.
      in_valid = 1'b1; in_data = 8'h77;
      repeat (2) @(posedge clk);
      #1 in_valid = 1'b0;
      check("idle_ready", in_ready, 0);

      // Back-to-back incrementing bytes.
      do_start();
      for (int i = 0; i < NW; i++) send_data(DW'(i), 0);
      end_session(1'b0);

      // Gapped stream.
      do_start();
      for (int i = 0; i < NW; i++)
         send_data((i == 0) ? 8'h11 : (i == 1) ? 8'hF0 : DW'($urandom), (i == 0) ? 0 : 2);
      end_session(1'b0);

      // start pulsed mid-load is ignored.
      do_start();
      for (int i = 0; i < NW; i++) begin
         send_data(DW'($urandom), $urandom_range(0, 1));
         if (i == 5) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("midstart_busy", busy, 1);
            check("midstart_done", done, 0);
         end
      end
      end_session(1'b0);

      // Asynchronous reset mid-session.
      do_start();
      for (int i = 0; i < 7; i++) send_data(DW'($urandom), 0);
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      check("arst_we", ram_we, 0);
      check("arst_addr", ram_addr, 0);
      check("arst_data", ram_data, 0);
      check("arst_busy", busy, 0);
      check("arst_hold", cpu_hold, 0);
      check("arst_ready", in_ready, 0);
      check("arst_done", done, 0);
      @(posedge clk); #2 reset = 1'b0;
      @(posedge clk); #1;
      check("arst_idle_ready", in_ready, 0);
      check("arst_writes", wr_count, 7);
      for (int i = 0; i < 7; i++) check("retained_word", got_mem[i], exp_mem[i]);
      do_start();
      for (int i = 0; i < NW; i++) send_data(DW'($urandom), $urandom_range(0, 2));
      end_session(1'b0);

      // Restart directly from DONE.
      do_start();
      for (int i = 0; i < NW; i++) send_data(8'hAA, 0);
      end_session(1'b0);

      // Checksum good (0x10) then bad (0x11).
      do_start();
      for (int i = 0; i < NW; i++) send_data(8'h01, 0);
      end_session(1'b0);
      do_start();
      for (int i = 0; i < NW; i++) send_data(8'h01, 0);
      end_session(1'b1);

      // Random sessions.
      for (int s = 0; s < 3; s++) begin
         bad = 1'($urandom_range(0, 1));
         do_start();
         for (int i = 0; i < NW; i++) send_data(DW'($urandom), $urandom_range(0, 3));
         end_session(bad);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
